// File: rtl/tok_ring_arbiter_if.sv
// Request/grant bundle between a token-ring arbiter (slave) and its requesters (master).
// The master drives req and ring_clear. The slave drives grant and token status.
interface tok_ring_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int HOLD_W = 3,
  parameter int POS_W  = 2
);
  logic              ring_clear;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   grant;
  logic [POS_W-1:0]  tok_pos;
  logic              tok_inject;
  logic              busy;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output ring_clear, req,
    input  grant, tok_pos, tok_inject, busy, hold_cnt
  );

  modport slave (
    input  ring_clear, req,
    output grant, tok_pos, tok_inject, busy, hold_cnt
  );
endinterface

// File: rtl/tok_ring_arbiter.sv
// Token-ring arbiter: one circulating one-hot token grants one requester at a time.
// Tenure is bounded to HOLD_MAX cycles, and the token always moves on after a release.
module tok_ring_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1,
  parameter int POS_W    = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  tok_ring_arbiter_if.slave bus
);

  typedef enum logic [1:0] {INIT, PASS, HOLD} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  state_t            state;
  logic [NREQ-1:0]   ring;
  logic [NREQ-1:0]   grant_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              inject_r;
  logic              tok_req;

  function automatic logic [NREQ-1:0] rotate(input logic [NREQ-1:0] r);
    return {r[NREQ-2:0], r[NREQ-1]};
  endfunction

  function automatic logic [POS_W-1:0] encode(input logic [NREQ-1:0] r);
    logic [POS_W-1:0] e;
    e = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) e = e | POS_W'(i);
    end
    return e;
  endfunction

  // Only the request at the token's stage matters; others are ignored.
  assign tok_req = |(bus.req & ring);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      ring       <= '0;
      grant_r    <= '0;
      hold_cnt_r <= '0;
      inject_r   <= 1'b0;
    end else if (bus.ring_clear) begin
      state      <= INIT;
      ring       <= '0;
      grant_r    <= '0;
      hold_cnt_r <= '0;
      inject_r   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ring     <= NREQ'(1);
          inject_r <= 1'b1;
          state    <= PASS;
        end
        PASS: begin
          inject_r <= 1'b0;
          if (tok_req) begin
            grant_r    <= ring;
            hold_cnt_r <= '0;
            state      <= HOLD;
          end else begin
            ring <= rotate(ring);
          end
        end
        HOLD: begin
          inject_r <= 1'b0;
          // Release always advances the token, so a persistent requester cannot starve the ring.
          if (!tok_req || hold_cnt_r == HOLD_LAST) begin
            grant_r    <= '0;
            ring       <= rotate(ring);
            hold_cnt_r <= '0;
            state      <= PASS;
          end else begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
          end
        end
        default: begin
          state      <= INIT;
          ring       <= '0;
          grant_r    <= '0;
          hold_cnt_r <= '0;
          inject_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_r;
  assign bus.tok_pos    = encode(ring);
  assign bus.tok_inject = inject_r;
  assign bus.busy       = |grant_r;
  assign bus.hold_cnt   = hold_cnt_r;

endmodule
